command_issue_queue: RTL and testbench



---
 rtl/command_issue_queue.sv | 143 ++++++++++++++
 tb/tb_command_issue_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/command_issue_queue.sv
// Command FIFO in front of the register-file controller: issues one command at
// a time as a registered command word plus a one-cycle syscall strobe.
module command_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int CMD_W   = 12,
    parameter int ALU_GAP = 1,
    parameter int CAS_GAP = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CMD_W-1:0]       cmd_in,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   hold,
    input  logic                   flush,
    output logic [CMD_W-1:0]       command,
    output logic                   syscall,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic [15:0]            issued_count,
    output logic                   dbg_state
);

    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = PW + 1;
    localparam int MAXG = (CAS_GAP > ALU_GAP) ? CAS_GAP : ALU_GAP;
    localparam int GW   = (MAXG < 1) ? 1 : $clog2(MAXG + 1);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GW-1:0]    gap_cnt;
    logic [GW-1:0]    gap_cnt_nxt;
    logic [CMD_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CMD_W-1:0] head;
    logic [GW-1:0]    head_gap;
    logic             full;
    logic             empty;
    logic             push;
    logic             issue;
    logic             issue_ok;

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends only on occupancy (no bypass).
    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full && !flush;

    assign head     = mem[rd_ptr];
    assign head_gap = (head[CMD_W-1 -: 3] == 3'b111) ? GW'(CAS_GAP) : GW'(ALU_GAP);
    assign issue_ok = !empty && !hold && !flush;

    assign busy      = (state == GAP) || syscall;
    assign dbg_state = (state == GAP);

    // gap_cnt holds the idle cycles still owed; the GAP cycle where it reads
    // zero is the last gap cycle, so the next issue may start at its edge.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        issue       = 1'b0;
        case (state)
            IDLE: begin
                if (issue_ok) begin
                    issue       = 1'b1;
                    gap_cnt_nxt = head_gap;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_cnt_nxt = gap_cnt - GW'(1);
                end else if (issue_ok) begin
                    issue       = 1'b1;
                    gap_cnt_nxt = head_gap;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                gap_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            command      <= '0;
            syscall      <= 1'b0;
            issued_count <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
            syscall <= issue;
            if (issue) begin
                command      <= head;
                issued_count <= issued_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, issue})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; level and the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

endmodule

// File: tb/tb_command_issue_queue.sv
// Directed bench for command_issue_queue: a per-cycle monitor compares the DUT
// against a command scoreboard and a spacing/busy model derived from issued ops.
module tb_command_issue_queue;

    localparam int DEPTH = 8;
    localparam int CMD_W = 12;

    logic             clk;
    logic             rst_n;
    logic [CMD_W-1:0] cmd_in;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             hold;
    logic             flush;
    logic [CMD_W-1:0] command;
    logic             syscall;
    logic [3:0]       level;
    logic             busy;
    logic [15:0]      issued_count;
    logic             dbg_state;

    // Zero-gap instance, used for back-to-back issue and the counter wrap.
    logic [CMD_W-1:0] cmd_in0;
    logic             cmd_valid0;
    logic             cmd_ready0;
    logic [CMD_W-1:0] command0;
    logic             syscall0;
    logic [3:0]       level0;
    logic             busy0;
    logic [15:0]      issued_count0;
    logic             dbg_state0;

    logic [CMD_W-1:0] exp_q[$];
    int               pulse_log[$];
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    int               last_cyc = 0;
    int               last_gap = 0;
    bit               last_valid = 1'b0;
    logic [CMD_W-1:0] exp_cmd = '0;
    logic [15:0]      exp_cnt = '0;
    int               n0;

    command_issue_queue #(.DEPTH(DEPTH), .CMD_W(CMD_W), .ALU_GAP(1), .CAS_GAP(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .hold(hold), .flush(flush), .command(command),
        .syscall(syscall), .level(level), .busy(busy),
        .issued_count(issued_count), .dbg_state(dbg_state)
    );

    command_issue_queue #(.DEPTH(DEPTH), .CMD_W(CMD_W), .ALU_GAP(0), .CAS_GAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in0), .cmd_valid(cmd_valid0),
        .cmd_ready(cmd_ready0), .hold(1'b0), .flush(1'b0), .command(command0),
        .syscall(syscall0), .level(level0), .busy(busy0),
        .issued_count(issued_count0), .dbg_state(dbg_state0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // One clock: acceptance is predicted from the scoreboard before the edge.
    task automatic tick();
        logic acc;
        logic clr;
        clr = !rst_n || flush;
        acc = cmd_valid && !clr && (exp_q.size() < DEPTH);
        @(posedge clk);
        #1;
        if (clr) exp_q.delete();
        else if (acc) exp_q.push_back(cmd_in);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_cmd(input logic [CMD_W-1:0] c);
        cmd_in    = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Monitor: runs 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (!rst_n) begin
            last_valid = 1'b0;
            exp_cmd    = '0;
            exp_cnt    = '0;
        end else if (syscall) begin
            pulse_log.push_back(cyc);
            if (last_valid) chk("issue_spacing", 32'(cyc - last_cyc >= last_gap + 1), 1);
            chk("issue_from_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) exp_cmd = exp_q.pop_front();
            exp_cnt    = exp_cnt + 16'd1;
            last_valid = 1'b1;
            last_cyc   = cyc;
            last_gap   = (exp_cmd[11:9] == 3'b111) ? 2 : 1;
        end
        chk("command", 32'(command), 32'(exp_cmd));
        chk("issued_count", 32'(issued_count), 32'(exp_cnt));
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_q.size() != DEPTH));
        chk("busy", 32'(busy), 32'(last_valid && (cyc - last_cyc <= last_gap)));
    end

    initial begin
        rst_n      = 1'b0;
        cmd_in     = '0;
        cmd_valid  = 1'b0;
        hold       = 1'b0;
        flush      = 1'b0;
        cmd_in0    = '0;
        cmd_valid0 = 1'b0;
        idle(2);
        rst_n = 1'b1;
        chk("rst_syscall", 32'(syscall), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_state", 32'(dbg_state), 0);

        // Single ALU command: one-cycle latency, one-cycle pulse, command held.
        push_cmd(12'h0C8);
        chk("t1_no_early_pulse", 32'(syscall), 0);
        tick();
        chk("t1_pulse", 32'(syscall), 1);
        chk("t1_command", 32'(command), 32'h0C8);
        chk("t1_state_gap", 32'(dbg_state), 1);
        tick();
        chk("t1_pulse_end", 32'(syscall), 0);
        chk("t1_held", 32'(command), 32'h0C8);
        chk("t1_count", 32'(issued_count), 1);
        idle(3);

        // ALU, CAS, ALU back to back: pulses at t, t+2, t+5.
        pulse_log.delete();
        cmd_valid = 1'b1;
        cmd_in = 12'h0C8; tick();
        cmd_in = 12'hE53; tick();
        cmd_in = 12'h251; tick();
        cmd_valid = 1'b0;
        idle(10);
        chk("t2_pulses", 32'(pulse_log.size()), 3);
        if (pulse_log.size() == 3) begin
            chk("t2_gap_alu", 32'(pulse_log[1] - pulse_log[0]), 2);
            chk("t2_gap_cas", 32'(pulse_log[2] - pulse_log[0]), 5);
        end
        chk("t2_last_cmd", 32'(command), 32'h251);

        // Fill under hold, overflow push ignored, then drain in order.
        hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_cmd({3'(i % 7), 9'(i * 37 + 5)});
        chk("t3_level_full", 32'(level), DEPTH);
        chk("t3_ready_low", 32'(cmd_ready), 0);
        push_cmd(12'h1FF);
        chk("t3_overflow_dropped", 32'(level), DEPTH);
        pulse_log.delete();
        hold = 1'b0;
        tick();
        chk("t3_ready_after_pop", 32'(cmd_ready), 1);
        idle(20);
        chk("t3_pulses", 32'(pulse_log.size()), DEPTH);
        for (int i = 1; i < pulse_log.size(); i++)
            chk("t3_spacing", 32'(pulse_log[i] - pulse_log[i-1]), 2);

        // Flush during a CAS gap with a simultaneous push.
        hold = 1'b1;
        push_cmd(12'hFAB);
        for (int i = 0; i < 4; i++) push_cmd(12'h012 + 12'(i * 34));
        pulse_log.delete();
        hold = 1'b0;
        tick();
        chk("t4_cas_pulse", 32'(syscall), 1);
        chk("t4_level4", 32'(level), 4);
        hold      = 1'b1;
        flush     = 1'b1;
        cmd_valid = 1'b1;
        cmd_in    = 12'h0AA;
        tick();
        flush     = 1'b0;
        cmd_valid = 1'b0;
        hold      = 1'b0;
        chk("t4_flushed", 32'(level), 0);
        chk("t4_gap_continues", 32'(busy), 1);
        idle(8);
        chk("t4_no_more_pulses", 32'(pulse_log.size()), 1);
        chk("t4_cmd_kept", 32'(command), 32'hFAB);

        // Reset while syscall is high with entries queued.
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(12'h101 + 12'(i));
        hold = 1'b0;
        tick();
        chk("t5_pulse", 32'(syscall), 1);
        chk("t5_level3", 32'(level), 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_syscall", 32'(syscall), 0);
        chk("t5_level", 32'(level), 0);
        chk("t5_command", 32'(command), 0);
        chk("t5_count", 32'(issued_count), 0);
        chk("t5_busy", 32'(busy), 0);
        push_cmd(12'h3A5);
        tick();
        chk("t5_restart_pulse", 32'(syscall), 1);
        chk("t5_restart_cmd", 32'(command), 32'h3A5);
        idle(3);
        chk("t5_restart_count", 32'(issued_count), 1);

        // Zero-gap instance: 65537 back-to-back issues wrap the counter to 1.
        n0         = 0;
        cmd_in0    = 12'h0C8;
        cmd_valid0 = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            tick();
            if (syscall0) n0++;
        end
        cmd_valid0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (syscall0) n0++;
        end
        chk("t6_pulse_total", 32'(n0), 65537);
        chk("t6_count_wrap", 32'(issued_count0), 1);
        chk("t6_level", 32'(level0), 0);
        chk("t6_ready", 32'(cmd_ready0), 1);
        chk("t6_idle", 32'({busy0, dbg_state0}), 0);
        chk("t6_command", 32'(command0), 32'h0C8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
